// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: one countdown per architectural register tracks
// cycles until its pending result is written back. Issue is blocked on RAW,
// WAW and writeback-port (structural) conflicts.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int LAT_W = 3,
  parameter int NWB   = 1,
  parameter int FWD   = 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      iss_valid,
  input  logic                      iss_use_rs1,
  input  logic                      iss_use_rs2,
  input  logic [$clog2(NREG)-1:0]   iss_rs1,
  input  logic [$clog2(NREG)-1:0]   iss_rs2,
  input  logic                      iss_we,
  input  logic [$clog2(NREG)-1:0]   iss_rd,
  input  logic [LAT_W-1:0]          iss_lat,
  input  logic                      flush,
  output logic                      stall,
  output logic                      iss_fire,
  output logic [NREG-1:0]           busy_vec,
  output logic [31:0]               stall_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic             raw1, raw2, waw, strct, wr_ok;
  logic [LAT_W:0]   lat_p1;
  logic [CW-1:0]    land_hits;

  // Hazard detection and issue handshake from current countdown state
  always_comb begin
    raw1   = 1'b0;
    raw2   = 1'b0;
    wr_ok  = iss_we && (iss_rd != '0);
    lat_p1 = {1'b0, iss_lat} + (LAT_W+1)'(1);
    land_hits = '0;

    if (iss_use_rs1 && iss_rs1 != '0)
      raw1 = (FWD != 0) ? (cnt_q[iss_rs1] > LAT_ONE) : (cnt_q[iss_rs1] != '0);
    if (iss_use_rs2 && iss_rs2 != '0)
      raw2 = (FWD != 0) ? (cnt_q[iss_rs2] > LAT_ONE) : (cnt_q[iss_rs2] != '0);

    waw = wr_ok && (cnt_q[iss_rd] > iss_lat);

    // A register at lat+1 now lands in the same cycle the new result would;
    // lat_p1 is one bit wider so LMAX+1 can never match a count.
    for (int unsigned r = 1; r < NREG; r++)
      if ({1'b0, cnt_q[r]} == lat_p1)
        land_hits = land_hits + CW'(1);
    strct = wr_ok && (iss_lat != '0) && (land_hits >= CW'(NWB));

    stall    = iss_valid && !flush && (raw1 || raw2 || waw || strct);
    iss_fire = iss_valid && !stall && !flush;
  end

  // Countdown next state: flush clears, issue load beats decrement
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (flush || r == 0)
        cnt_d[r] = '0;
      else if (iss_fire && wr_ok && iss_lat != '0 && iss_rd == AW'(r))
        cnt_d[r] = iss_lat;
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - LAT_ONE;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      for (int unsigned r = 0; r < NREG; r++)
        cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++)
        cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy flags derived from registered counts
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++)
      busy_vec[r] = (cnt_q[r] != '0);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: two scoreboards share one stimulus stream; u_a has
// forwarding and one writeback port, u_b has no forwarding and two ports.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        iss_valid, iss_use_rs1, iss_use_rs2, iss_we, flush;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic [2:0]  iss_lat;
  logic        stall_a, fire_a, stall_b, fire_b;
  logic [31:0] busy_a, busy_b, scnt_a, scnt_b;

  int errors = 0;
  int checks = 0;

  hazard_scoreboard #(.NREG(32), .LAT_W(3), .NWB(1), .FWD(1)) u_a (
    .clk(clk), .nrst(nrst), .iss_valid(iss_valid),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_we(iss_we), .iss_rd(iss_rd),
    .iss_lat(iss_lat), .flush(flush), .stall(stall_a), .iss_fire(fire_a),
    .busy_vec(busy_a), .stall_cnt(scnt_a)
  );

  hazard_scoreboard #(.NREG(32), .LAT_W(3), .NWB(2), .FWD(0)) u_b (
    .clk(clk), .nrst(nrst), .iss_valid(iss_valid),
    .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_we(iss_we), .iss_rd(iss_rd),
    .iss_lat(iss_lat), .flush(flush), .stall(stall_b), .iss_fire(fire_b),
    .busy_vec(busy_b), .stall_cnt(scnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    iss_valid = 1'b0; iss_use_rs1 = 1'b0; iss_use_rs2 = 1'b0; iss_we = 1'b0;
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0; iss_lat = '0; flush = 1'b0;
  endtask

  task automatic set_wr(input logic [4:0] rd, input logic [2:0] lat);
    set_idle();
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = rd; iss_lat = lat;
  endtask

  task automatic set_rd1(input logic [4:0] rs);
    set_idle();
    iss_valid = 1'b1; iss_use_rs1 = 1'b1; iss_rs1 = rs;
  endtask

  task automatic do_reset();
    set_idle();
    nrst = 1'b1;
    tick();
    tick();
    nrst = 1'b0;
  endtask

  initial begin
    set_idle();
    #3;
    check("rst_busy_a", busy_a, 32'h0);
    check("rst_scnt_a", scnt_a, 32'h0);
    check("rst_busy_b", busy_b, 32'h0);
    do_reset();

    // RAW: rd=5 lat=2, read when count has reached 1
    set_wr(5'd5, 3'd2); #1;
    check("raw_iss_fire_a", fire_a, 1);
    check("raw_iss_fire_b", fire_b, 1);
    tick();
    set_idle(); tick();
    set_rd1(5'd5); #1;
    check("raw_fwd_stall", stall_a, 0);
    check("raw_fwd_fire", fire_a, 1);
    check("raw_nofwd_stall", stall_b, 1);
    check("raw_nofwd_fire", fire_b, 0);
    tick(); #1;
    check("raw_nofwd_fire2", fire_b, 1);
    check("raw_nofwd_scnt", scnt_b, 1);
    check("raw_fwd_scnt", scnt_a, 0);
    tick();

    // WAW: rd=7 lat=6, then rd=7 lat=2 waits three cycles
    do_reset();
    set_wr(5'd7, 3'd6); tick();
    set_idle(); tick();
    set_wr(5'd7, 3'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("waw_stall", stall_a, 1);
      check("waw_busy7", busy_a[7], 1);
      tick();
    end
    #1;
    check("waw_fire", fire_a, 1);
    check("waw_scnt", scnt_a, 3);
    tick();
    set_idle(); #1;
    check("waw_busy7_after", busy_a[7], 1);

    // Structural: rd=3 lat=4 at count 3 collides with rd=4 lat=2
    do_reset();
    set_wr(5'd3, 3'd4); tick();
    set_idle(); tick();
    set_wr(5'd4, 3'd2); #1;
    check("str_nwb1_stall", stall_a, 1);
    check("str_nwb1_fire", fire_a, 0);
    check("str_nwb2_fire", fire_b, 1);
    tick();
    set_idle(); #1;
    check("str_busy_b", busy_b, 32'h0000_0018);
    check("str_busy_a", busy_a, 32'h0000_0008);

    // Flush with a valid (would-be-stalled) instruction
    do_reset();
    set_wr(5'd9, 3'd5); tick();
    set_wr(5'd10, 3'd5); tick();
    set_wr(5'd11, 3'd5); #1;
    check("fl_fire11", fire_a, 1);
    tick();
    set_idle(); #1;
    check("fl_busy_pre", busy_a, 32'h0000_0E00);
    set_wr(5'd12, 3'd3); flush = 1'b1; #1;
    check("fl_fire", fire_a, 0);
    check("fl_stall", stall_a, 0);
    tick();
    set_idle(); #1;
    check("fl_busy_a", busy_a, 32'h0);
    check("fl_busy_b", busy_b, 32'h0);

    // x0 never tracked, lat=0 untracked, lat=LMAX never structural
    do_reset();
    set_wr(5'd0, 3'd7); #1;
    check("x0_fire", fire_a, 1);
    tick();
    set_idle(); #1;
    check("x0_busy", busy_a, 32'h0);
    set_rd1(5'd0); #1;
    check("x0_rd_stall", stall_a, 0);
    check("x0_rd_fire", fire_a, 1);
    tick();
    set_wr(5'd6, 3'd0); #1;
    check("lat0_fire", fire_a, 1);
    tick();
    set_idle(); #1;
    check("lat0_busy", busy_a, 32'h0);
    set_wr(5'd1, 3'd7); tick();
    set_wr(5'd2, 3'd7); #1;
    check("lmax_fire", fire_a, 1);
    tick();
    set_idle(); #1;
    check("lmax_busy", busy_a, 32'h0000_0006);

    // Asynchronous reset between edges with rd=12 pending
    do_reset();
    set_wr(5'd12, 3'd5); tick();
    set_rd1(5'd12); #1;
    check("ar_stall", stall_a, 1);
    tick();
    set_idle(); #1;
    check("ar_scnt_pre", scnt_a, 1);
    check("ar_busy_pre", busy_a, 32'h0000_1000);
    #2;
    nrst = 1'b1; #1;
    check("ar_busy_a", busy_a, 32'h0);
    check("ar_scnt_a", scnt_a, 32'h0);
    check("ar_busy_b", busy_b, 32'h0);
    #1;
    nrst = 1'b0;
    set_rd1(5'd12); #1;
    check("ar_post_stall", stall_a, 0);
    check("ar_post_fire", fire_a, 1);
    tick();
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: number of architectural registers tracked.
REQ-002 SHALL have parameter LAT_W, default 3: latency field width; maximum latency LMAX = 2^LAT_W-1.
REQ-003 SHALL have parameter NWB, default 1: writeback ports available per cycle, range 1..4.
REQ-004 SHALL have parameter FWD, default 1: 1 = forwarding present, so a source due in 1 cycle is not a hazard.
REQ-005 SHALL have ports, in order (AW = clog2(NREG)):
- clk  in  1  clock, rising edge.
- nrst  in  1  reset; asynchronous, active-high (asserted = 1 resets).
- iss_valid  in  1  instruction presented for issue.
- iss_use_rs1 / iss_use_rs2  in  1 each  source operand read.
- iss_rs1 / iss_rs2  in  AW each  source register addresses.
- iss_we  in  1  instruction writes rd.
- iss_rd  in  AW  destination address.
- iss_lat  in  LAT_W  cycles until result writeback; 0 = untracked.
- flush  in  1  squash all in-flight results (exception/branch taken).
- stall  out  1  issue blocked this cycle.
- iss_fire  out  1  instruction accepted this cycle.
- busy_vec  out  NREG  bit r = 1 while register r has a pending result.
- stall_cnt  out  32  saturating count of stalled cycles.

Function
REQ-006 SHALL hold one LAT_W-bit countdown cnt[r] per register r; register 0 never tracked, cnt[0] = 0 always.
REQ-007 SHALL decrement every nonzero cnt[r] by 1 each clock, with no wrap below 0.
REQ-008 SHALL, on iss_fire with iss_we=1, iss_rd!=0, iss_lat>0, load cnt[iss_rd] <= iss_lat; the load wins over the same-cycle decrement.
REQ-009 SHALL raise a RAW hazard per source when use=1, addr!=0, and either cnt>1 (FWD=1) or cnt!=0 (FWD=0).
REQ-010 SHALL raise a WAW hazard when iss_we=1, iss_rd!=0 and cnt[iss_rd] > iss_lat, because the older write would land after the younger one.
REQ-011 SHALL raise a structural hazard when iss_we=1, iss_rd!=0, iss_lat>0 and the count of registers with cnt == iss_lat+1 is >= NWB.
- When iss_lat = LMAX this condition is never true.
REQ-012 SHALL drive stall = iss_valid & !flush & (RAW1 | RAW2 | WAW | STRUCT), combinationally, in the same cycle.
REQ-013 SHALL drive iss_fire = iss_valid & !stall & !flush.
REQ-014 SHALL, on flush=1, clear all cnt[r] to 0 at the next edge; flush has priority over a same-cycle load.
REQ-015 SHALL drive busy_vec[r] = (cnt[r] != 0) from registered state.
REQ-016 SHALL increment stall_cnt on each clock with stall=1 and hold it at 0xFFFFFFFF once reached.
REQ-017 SHALL ignore iss_rd, iss_rs1, iss_rs2 and iss_lat when iss_valid=0.

Reset
REQ-018 SHALL, while nrst=1, asynchronously set all cnt[r]=0, busy_vec=0 and stall_cnt=0; stall and iss_fire then follow REQ-012/013 from the cleared state.
REQ-019 SHALL treat reset asserted mid-operation as discarding every pending result; the first cycle after release behaves as an empty scoreboard.

Verification
REQ-020 SHALL pass RAW with forwarding: FWD=1, issue rd=5 lat=2, then next cycle rs1=5 -> no stall (cnt=1), iss_fire=1; with FWD=0 the same sequence -> stall=1 for 1 cycle, stall_cnt=1.
REQ-021 SHALL pass WAW: issue rd=7 lat=6, then next cycle rd=7 lat=2 -> stall until cnt[7] <= 2 (3 stall cycles), then fire; busy_vec[7] stays 1 throughout.
REQ-022 SHALL pass structural: NWB=1, issue rd=3 lat=4, then next cycle rd=4 lat=2 -> stall=1 (cnt[3]=3); at NWB=2 -> fire.
REQ-023 SHALL pass flush: rd=9,10,11 pending with lat 5, assert flush with iss_valid=1 -> iss_fire=0, stall=0, busy_vec=0 next cycle.
REQ-024 SHALL pass the x0 case: issue rd=0 lat=7, then rs1=0 -> no busy bit, no stall.
REQ-025 SHALL pass async reset: assert nrst between edges with rd=12 pending -> busy_vec=0 immediately, stall_cnt=0.
